// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } arb_state_e;

  localparam int         SPI_SLAVES = 4;
  localparam int         SEL_W      = $clog2(SPI_SLAVES);
  localparam logic [7:0] ABORT_DATA = 8'hFF;

  // Next requester index after idx, wrapping back to 0 at modulus.
  function automatic int wrap_inc(input int idx, input int modulus);
    if (idx + 1 >= modulus) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Requester-side and SPI-host-side signals of the transaction arbiter.
interface spi_txn_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import spi_arb_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*8-1:0]     req_data;
  logic [NUM_REQ*SEL_W-1:0] req_slave;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [7:0]               rsp_data;
  logic                     spi_start;
  logic [7:0]               spi_tx_data;
  logic [SEL_W-1:0]         spi_slave_sel;
  logic                     spi_ready;
  logic [7:0]               spi_rx_data;
  logic                     busy;
  logic                     timeout_err;

  // The arbiter side: it grants requesters and masters the SPI host.
  modport master (
    input  req_valid, req_data, req_slave, spi_ready, spi_rx_data,
    output req_ready, rsp_valid, rsp_data, spi_start, spi_tx_data,
           spi_slave_sel, busy, timeout_err
  );

  // The environment side: requesters plus the SPI host.
  modport slave (
    output req_valid, req_data, req_slave, spi_ready, spi_rx_data,
    input  req_ready, rsp_valid, rsp_data, spi_start, spi_tx_data,
           spi_slave_sel, busy, timeout_err
  );

endinterface

// File: rtl/spi_txn_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module spi_rr_picker
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W-1:0] cur_s;

  // Walk the requesters starting at ptr and keep the first one asserted.
  always_comb begin
    grant = {NUM_REQ{1'b0}};
    idx   = {PTR_W{1'b0}};
    any   = 1'b0;
    cur_s = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[cur_s]) begin
        any          = 1'b1;
        idx          = cur_s;
        grant[cur_s] = 1'b1;
      end else begin
        any = any;
      end
      cur_s = PTR_W'(wrap_inc(int'(cur_s), NUM_REQ));
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sharing of one SPI host among NUM_REQ requesters, one byte in flight.
// Optional abort timer enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst,
  spi_txn_arbiter_if.master  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("spi_txn_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  arb_state_e         state_r, state_nxt_s;
  logic [PTR_W-1:0]   ptr_r, ptr_nxt_s;
  logic [PTR_W-1:0]   winner_r, winner_nxt_s;
  logic [PTR_W-1:0]   pick_idx_s;
  logic [NUM_REQ-1:0] pick_grant_s;
  logic               pick_any_s;
  logic [NUM_REQ-1:0] req_ready_r, req_ready_nxt_s;
  logic [NUM_REQ-1:0] rsp_valid_r, rsp_valid_nxt_s;
  logic [7:0]         rsp_data_r, rsp_data_nxt_s;
  logic [7:0]         tx_data_r, tx_data_nxt_s;
  logic [SEL_W-1:0]   slave_sel_r, slave_sel_nxt_s;
  logic               spi_start_r, spi_start_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               timeout_err_r, timeout_err_nxt_s;
  logic               timeout_hit_s;

  spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req_valid),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_r;

  // Cycles spent in ISSUE/WAIT_DONE; zero whenever idle so each grant starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == IDLE) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ISSUE || state_r == WAIT_DONE) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  assign timeout_hit_s = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt_s       = state_r;
    ptr_nxt_s         = ptr_r;
    winner_nxt_s      = winner_r;
    req_ready_nxt_s   = {NUM_REQ{1'b0}};
    rsp_valid_nxt_s   = {NUM_REQ{1'b0}};
    rsp_data_nxt_s    = rsp_data_r;
    tx_data_nxt_s     = tx_data_r;
    slave_sel_nxt_s   = slave_sel_r;
    spi_start_nxt_s   = spi_start_r;
    timeout_err_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.spi_ready && pick_any_s) begin
          winner_nxt_s    = pick_idx_s;
          tx_data_nxt_s   = bus.req_data[int'(pick_idx_s) * 8 +: 8];
          slave_sel_nxt_s = bus.req_slave[int'(pick_idx_s) * SEL_W +: SEL_W];
          req_ready_nxt_s = pick_grant_s;
          spi_start_nxt_s = 1'b1;
          state_nxt_s     = ISSUE;
        end else begin
          spi_start_nxt_s = 1'b0;
        end
      end
      ISSUE, WAIT_DONE: begin
        if (timeout_hit_s) begin
          // Abort: answer the requester with the abort byte and free the host.
          spi_start_nxt_s   = 1'b0;
          rsp_data_nxt_s    = ABORT_DATA;
          rsp_valid_nxt_s   = {{(NUM_REQ - 1){1'b0}}, 1'b1} << winner_r;
          timeout_err_nxt_s = 1'b1;
          ptr_nxt_s         = PTR_W'(wrap_inc(int'(winner_r), NUM_REQ));
          state_nxt_s       = IDLE;
        end else if (state_r == ISSUE) begin
          if (!bus.spi_ready) begin
            spi_start_nxt_s = 1'b0;
            state_nxt_s     = WAIT_DONE;
          end else begin
            spi_start_nxt_s = 1'b1;
          end
        end else if (bus.spi_ready) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      RESP: begin
        rsp_data_nxt_s  = bus.spi_rx_data;
        rsp_valid_nxt_s = {{(NUM_REQ - 1){1'b0}}, 1'b1} << winner_r;
        ptr_nxt_s       = PTR_W'(wrap_inc(int'(winner_r), NUM_REQ));
        state_nxt_s     = IDLE;
      end
      default: begin
        spi_start_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      ptr_r         <= {PTR_W{1'b0}};
      winner_r      <= {PTR_W{1'b0}};
      req_ready_r   <= {NUM_REQ{1'b0}};
      rsp_valid_r   <= {NUM_REQ{1'b0}};
      rsp_data_r    <= 8'h00;
      tx_data_r     <= 8'h00;
      slave_sel_r   <= {SEL_W{1'b0}};
      spi_start_r   <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      ptr_r         <= ptr_nxt_s;
      winner_r      <= winner_nxt_s;
      req_ready_r   <= req_ready_nxt_s;
      rsp_valid_r   <= rsp_valid_nxt_s;
      rsp_data_r    <= rsp_data_nxt_s;
      tx_data_r     <= tx_data_nxt_s;
      slave_sel_r   <= slave_sel_nxt_s;
      spi_start_r   <= spi_start_nxt_s;
      busy_r        <= busy_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
    end
  end

  assign bus.req_ready     = req_ready_r;
  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_data      = rsp_data_r;
  assign bus.spi_start     = spi_start_r;
  assign bus.spi_tx_data   = tx_data_r;
  assign bus.spi_slave_sel = slave_sel_r;
  assign bus.busy          = busy_r;
  assign bus.timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: host model, transaction-age reference model, directed scenarios.
module tb_spi_txn_arbiter;

  localparam int N        = 4;
  localparam int TOC      = 15;
  localparam int HOST_LAT = 20;
  // grant cycle -> host drops ready -> HOST_LAT cycles -> RESP -> response visible
  localparam int RSP_AGE  = HOST_LAT + 2;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   force_low = 1'b0;
  bit   host_hang = 1'b0;

  logic [7:0] tx_tab  [N] = '{8'hA5, 8'hB2, 8'hC7, 8'hD4};
  logic [1:0] sel_tab [N] = '{2'd2, 2'd1, 2'd0, 2'd3};
  logic [7:0] rsp_tab [N] = '{8'h99, 8'h8E, 8'hFB, 8'hE8};

  spi_txn_arbiter_if #(.NUM_REQ(N)) bus ();

  spi_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TOC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.spi_start,
                bus.spi_tx_data, bus.spi_slave_sel, bus.busy, bus.timeout_err});
  endfunction

  // SPI host: drops ready one cycle after start, raises it HOST_LAT cycles later.
  initial begin : host
    bit         hbusy;
    int         hcnt;
    logic [7:0] htx;
    hbusy = 1'b0;
    hcnt  = 0;
    htx   = 8'h00;
    bus.spi_ready   = 1'b1;
    bus.spi_rx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (hbusy) begin
        hcnt++;
        if (hcnt >= HOST_LAT && !host_hang) begin
          bus.spi_ready   = 1'b1;
          bus.spi_rx_data = htx ^ 8'h3C;
          hbusy           = 1'b0;
        end
      end else if (bus.spi_start && bus.spi_ready) begin
        hbusy         = 1'b1;
        hcnt          = 0;
        htx           = bus.spi_tx_data;
        bus.spi_ready = 1'b0;
      end else begin
        bus.spi_ready = !force_low;
      end
    end
  end

  // Reference model: transaction age since grant decides every output.
  initial begin : model
    int       m_ptr, m_win, m_age, m_done, base, c;
    bit       m_busy, m_abort, found;
    logic [3:0] oh;
    m_ptr = 0; m_win = 0; m_age = 0; m_done = 0;
    m_busy = 1'b0; m_abort = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", all_outs(), 32'd0);
        m_busy = 1'b0;
        m_ptr  = 0;
      end else begin
        if (m_busy) m_age++;
        oh = 4'b0001 << m_win;
        check("req_ready", 32'(bus.req_ready), (m_busy && m_age == 0) ? 32'(oh) : 32'd0);
        check("spi_start", 32'(bus.spi_start), 32'(m_busy && m_age == 0));
        check("busy", 32'(bus.busy), 32'(m_busy && m_age < m_done));
        check("rsp_valid", 32'(bus.rsp_valid), (m_busy && m_age == m_done) ? 32'(oh) : 32'd0);
        check("timeout_err", 32'(bus.timeout_err), 32'(m_busy && m_age == m_done && m_abort));
        if (m_busy && m_age == m_done)
          check("rsp_data", 32'(bus.rsp_data), 32'(m_abort ? 8'hFF : (tx_tab[m_win] ^ 8'h3C)));
        if (m_busy && m_age <= m_done)
          check("spi_tx", 32'({bus.spi_slave_sel, bus.spi_tx_data}), 32'({sel_tab[m_win], tx_tab[m_win]}));
        if (m_busy && m_age == m_done) begin
          m_busy = 1'b0;
          m_ptr  = (m_win + 1) % N;
        end
        if (!m_busy && bus.spi_ready && bus.req_valid != 4'b0000) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && bus.req_valid[c]) begin
              found = 1'b1;
              m_win = c;
            end
          end
          base    = host_hang ? 1000000 : RSP_AGE;
          m_abort = TO_ON && (TOC < base);
          m_done  = m_abort ? TOC : base;
          m_busy  = 1'b1;
          m_age   = -1;
        end
      end
    end
  end

  task automatic expect_grant(input int idx);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.req_ready == 4'b0000 && n < 200);
    check($sformatf("grant_%0d", idx), 32'(bus.req_ready), 32'(1) << idx);
  endtask

  task automatic expect_rsp(input int idx, input logic [7:0] data, input bit to_err);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.rsp_valid == 4'b0000 && n < 200);
    check($sformatf("rsp_valid_%0d", idx), 32'(bus.rsp_valid), 32'(1) << idx);
    check($sformatf("rsp_data_%0d", idx), 32'(bus.rsp_data), 32'(data));
    check($sformatf("rsp_to_%0d", idx), 32'(bus.timeout_err), 32'(to_err));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_pulse_outputs", all_outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int ord [8] = '{0, 1, 2, 3, 0, 2, 0, 2};
    bus.req_valid = 4'b0000;
    bus.req_data  = {tx_tab[3], tx_tab[2], tx_tab[1], tx_tab[0]};
    bus.req_slave = {sel_tab[3], sel_tab[2], sel_tab[1], sel_tab[0]};
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", all_outs(), 32'd0);
    rst = 1'b0;

    // Single requester 0
    bus.req_valid = 4'b0001;
    expect_grant(0);
    bus.req_valid = 4'b0000;
    check("t1_tx", 32'(bus.spi_tx_data), 32'(8'hA5));
    check("t1_sel", 32'(bus.spi_slave_sel), 32'(2'd2));
    expect_rsp(0, TO_ON ? 8'hFF : 8'h99, TO_ON);

    // All requesting, then only 0 and 2 after requester 3 is accepted
    pulse_reset();
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      expect_grant(ord[g]);
      if (g == 3) bus.req_valid = 4'b0101;
      if (g == 7) bus.req_valid = 4'b0000;
      expect_rsp(ord[g], TO_ON ? 8'hFF : rsp_tab[ord[g]], TO_ON);
    end

    // Host not ready while idle: no grant
    force_low = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("t4_no_grant", 32'(bus.req_ready), 32'd0);
    end
    force_low = 1'b0;
    expect_grant(1);
    bus.req_valid = 4'b0000;
    expect_rsp(1, TO_ON ? 8'hFF : 8'h8E, TO_ON);

    // Reset while waiting on the host
    bus.req_valid = 4'b0100;
    expect_grant(2);
    bus.req_valid = 4'b0000;
    repeat (5) @(posedge clk);
    #1;
    check("t5_busy_before_rst", 32'(bus.busy), 32'd1);
    pulse_reset();
    bus.req_valid = 4'b1011;
    expect_grant(0);
    bus.req_valid = 4'b0000;
    expect_rsp(0, TO_ON ? 8'hFF : 8'h99, TO_ON);

    // Host never finishes
    host_hang = 1'b1;
    bus.req_valid = 4'b0010;
    expect_grant(1);
    bus.req_valid = 4'b0000;
`ifdef SPI_ARB_TIMEOUT_EN
    expect_rsp(1, 8'hFF, 1'b1);
`else
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      check("t6_busy_held", 32'(bus.busy), 32'd1);
      check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
`endif
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
